// File: rtl/i2c_write_sequencer.sv
// I2C register-write frame sequencer: buffers payload bytes, then emits addr/reg/data bytes to a bit-level transmitter.
// Optional NACK retry is compiled in with `define I2C_SEQ_RETRY_EN.
module i2c_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int RETRY_MAX  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [3:0] cmd_len,
  input  logic       wr_data_valid,
  input  logic [7:0] wr_data,
  output logic       wr_data_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  output logic       tx_stop,
  input  logic       tx_ready,
  input  logic       ack_valid,
  input  logic       ack_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE, WAIT_DATA, SEND_ADDR, WAIT_ACK_ADDR, SEND_REG,
    WAIT_ACK_REG, SEND_DATA, WAIT_ACK_DATA, FINISH
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail, rd_ptr;
  logic [3:0]    count, len_r, sent;
  logic [6:0]    dev_r;
  logic [7:0]    reg_r;
  logic          push, pop, nack_in, give_up;

  assign fifo_count    = count;
  assign wr_data_ready = (count != DEPTH);
  assign push          = wr_data_valid && (count != DEPTH);
  assign busy          = (state != IDLE);
  assign cmd_ready     = (state == IDLE);
  assign nack_in       = ack_valid && ack_nack &&
                         (state == WAIT_ACK_ADDR || state == WAIT_ACK_REG || state == WAIT_ACK_DATA);

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1) + 1;
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
  logic [RW-1:0] retries;
  assign give_up = nack_in && (retries >= RMAX);
`else
  assign give_up = nack_in;
`endif

  // head only moves on frame commit or abandoned frame, so retries re-read the same bytes
  assign pop = (state == FINISH) || give_up;

  always_ff @(posedge clk)
    if (push) mem[tail] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + len_r[AW-1:0];
      count <= count + {3'b000, push} - (pop ? len_r : 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_byte  <= 8'h00;
      tx_start <= 1'b0;
      tx_stop  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      dev_r    <= '0;
      reg_r    <= '0;
      len_r    <= '0;
      sent     <= '0;
      rd_ptr   <= '0;
`ifdef I2C_SEQ_RETRY_EN
      retries  <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          dev_r  <= cmd_dev_addr;
          reg_r  <= cmd_reg_addr;
          len_r  <= cmd_len;
          sent   <= '0;
          rd_ptr <= head;
`ifdef I2C_SEQ_RETRY_EN
          retries <= '0;
`endif
          if (cmd_len > DEPTH) error <= 1'b1;
          else                 state <= WAIT_DATA;
        end
        WAIT_DATA: if (count >= len_r) begin
          state    <= SEND_ADDR;
          tx_valid <= 1'b1;
          tx_byte  <= {dev_r, 1'b0};
          tx_start <= 1'b1;
          tx_stop  <= 1'b0;
        end
        SEND_ADDR, SEND_REG, SEND_DATA: if (tx_ready) begin
          tx_valid <= 1'b0;
          tx_byte  <= 8'h00;
          tx_start <= 1'b0;
          tx_stop  <= 1'b0;
          if (state == SEND_ADDR)     state <= WAIT_ACK_ADDR;
          else if (state == SEND_REG) state <= WAIT_ACK_REG;
          else begin
            state  <= WAIT_ACK_DATA;
            rd_ptr <= rd_ptr + 1'b1;
            sent   <= sent + 4'd1;
          end
        end
        WAIT_ACK_ADDR: if (ack_valid && !ack_nack) begin
          state    <= SEND_REG;
          tx_valid <= 1'b1;
          tx_byte  <= reg_r;
          tx_stop  <= (len_r == 4'd0);
        end
        WAIT_ACK_REG, WAIT_ACK_DATA: if (ack_valid && !ack_nack) begin
          if (sent == len_r) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state    <= SEND_DATA;
            tx_valid <= 1'b1;
            tx_byte  <= mem[rd_ptr];
            tx_stop  <= (sent + 4'd1 == len_r);
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (nack_in) begin
        rd_ptr <= head;
        sent   <= '0;
      end
`ifdef I2C_SEQ_RETRY_EN
      if (nack_in && !give_up) begin
        retries  <= retries + 1'b1;
        state    <= SEND_ADDR;
        tx_valid <= 1'b1;
        tx_byte  <= {dev_r, 1'b0};
        tx_start <= 1'b1;
        tx_stop  <= 1'b0;
      end
`endif
      if (give_up) begin
        error <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer: frames, backpressure, FIFO edges, NACK and mid-frame reset.
module tb_i2c_write_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [6:0] cmd_dev_addr = '0;
  logic [7:0] cmd_reg_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       wr_data_valid = 1'b0, wr_data_ready;
  logic [7:0] wr_data = '0;
  logic       tx_valid, tx_start, tx_stop;
  logic [7:0] tx_byte;
  logic       tx_ready = 1'b0, ack_valid = 1'b0, ack_nack = 1'b0;
  logic       busy, done, error;
  logic [3:0] fifo_count;

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, err_cnt = 0;

  i2c_write_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_data_ready(wr_data_ready),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_start(tx_start), .tx_stop(tx_stop),
    .tx_ready(tx_ready), .ack_valid(ack_valid), .ack_nack(ack_nack),
    .busy(busy), .done(done), .error(error), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done)  done_cnt <= done_cnt + 1;
    if (error) err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    wr_data_valid = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_data_valid = 1'b0;
  endtask

  task automatic cmd(input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len);
    chk("cmd_ready", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_dev_addr = dev;
    cmd_reg_addr = rg;
    cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for an offered byte, checks it, optionally stalls, takes it and returns an ACK/NACK.
  task automatic xbyte(input string tag, input logic [7:0] b, input logic st, input logic sp,
                       input logic nack, input int hold, input logic give_ack);
    int t = 0;
    logic stable = 1'b1;
    while (!tx_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_vld"},   {31'd0, tx_valid}, 1);
    chk({tag, "_byte"},  {24'd0, tx_byte},  {24'd0, b});
    chk({tag, "_start"}, {31'd0, tx_start}, {31'd0, st});
    chk({tag, "_stop"},  {31'd0, tx_stop},  {31'd0, sp});
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (!tx_valid || tx_byte !== b) stable = 1'b0;
      end
      chk({tag, "_hold"}, {31'd0, stable}, 1);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_taken"}, {31'd0, tx_valid}, 0);
    if (give_ack) begin
      ack_valid = 1'b1;
      ack_nack = nack;
      @(negedge clk);
      ack_valid = 1'b0;
      ack_nack = 1'b0;
    end
  endtask

  // Called in the FINISH cycle: done high now, then idle with the given occupancy.
  task automatic frame_end(input string tag, input logic [3:0] cnt);
    int d0;
    d0 = done_cnt;
    chk({tag, "_done"}, {31'd0, done}, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
    chk({tag, "_idle"}, {31'd0, busy}, 0);
    chk({tag, "_count"}, {28'd0, fifo_count}, {28'd0, cnt});
    chk({tag, "_done_once"}, done_cnt, d0 + 1);
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    chk({tag, "_no_tx"}, {31'd0, seen}, 0);
  endtask

  initial begin
    int e0, d0;
    // reset
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_byte",  {24'd0, tx_byte}, 0);
    chk("rst_flags",    {28'd0, busy, done, error, tx_start | tx_stop}, 0);
    chk("rst_count",    {28'd0, fifo_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_wr_ready",  {31'd0, wr_data_ready}, 1);

    // stray ACK while idle is ignored
    ack_valid = 1'b1;
    @(negedge clk);
    ack_valid = 1'b0;
    chk("stray_ack_idle", {31'd0, busy}, 0);

    // basic 2-byte write
    push(8'hA5);
    push(8'h3C);
    chk("f1_count", {28'd0, fifo_count}, 2);
    cmd(7'h48, 8'h10, 4'd2);
    xbyte("f1_addr", 8'h90, 1, 0, 0, 0, 1);
    xbyte("f1_reg",  8'h10, 0, 0, 0, 0, 1);
    xbyte("f1_d0",   8'hA5, 0, 0, 0, 0, 1);
    xbyte("f1_d1",   8'h3C, 0, 1, 0, 0, 1);
    frame_end("f1", 4'd0);

    // zero-length write: stop rides on the register byte
    cmd(7'h27, 8'h05, 4'd0);
    xbyte("f2_addr", 8'h4E, 1, 0, 0, 0, 1);
    xbyte("f2_reg",  8'h05, 0, 1, 0, 0, 1);
    frame_end("f2", 4'd0);

    // command waits for its data, plus a 5-cycle downstream stall
    push(8'h11);
    cmd(7'h50, 8'h20, 4'd3);
    chk("f3_busy_wait", {31'd0, busy}, 1);
    quiet("f3_wait", 5);
    push(8'h22);
    push(8'h33);
    xbyte("f3_addr", 8'hA0, 1, 0, 0, 0, 1);
    xbyte("f3_reg",  8'h20, 0, 0, 0, 0, 1);
    xbyte("f3_d0",   8'h11, 0, 0, 0, 0, 1);
    xbyte("f3_d1",   8'h22, 0, 0, 0, 5, 1);
    xbyte("f3_d2",   8'h33, 0, 1, 0, 0, 1);
    frame_end("f3", 4'd0);

    // full FIFO drops the extra push; pointers wrap through the end of storage
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    chk("full_count", {28'd0, fifo_count}, 4);
    chk("full_ready", {31'd0, wr_data_ready}, 0);
    push(8'h05);
    chk("drop_count", {28'd0, fifo_count}, 4);
    cmd(7'h01, 8'h02, 4'd4);
    xbyte("f4_addr", 8'h02, 1, 0, 0, 0, 1);
    xbyte("f4_reg",  8'h02, 0, 0, 0, 0, 1);
    xbyte("f4_d0",   8'h01, 0, 0, 0, 0, 1);
    xbyte("f4_d1",   8'h02, 0, 0, 0, 0, 1);
    xbyte("f4_d2",   8'h03, 0, 0, 0, 0, 1);
    xbyte("f4_d3",   8'h04, 0, 1, 0, 0, 1);
    frame_end("f4", 4'd0);

    // oversize length: error pulse, stays idle, nothing transmitted
    e0 = err_cnt;
    cmd(7'h12, 8'h34, 4'd5);
    chk("big_error", {31'd0, error}, 1);
    chk("big_idle",  {30'd0, busy, ~cmd_ready}, 0);
    quiet("big", 4);
    chk("big_err_once", err_cnt, e0 + 1);

    // NACK on the address byte
    push(8'h77);
    e0 = err_cnt;
    cmd(7'h48, 8'h10, 4'd1);
`ifdef I2C_SEQ_RETRY_EN
    for (int i = 0; i < 4; i++) xbyte("nack_addr", 8'h90, 1, 0, 1, 0, 1);
`else
    xbyte("nack_addr", 8'h90, 1, 0, 1, 0, 1);
`endif
    chk("nack_error", {31'd0, error}, 1);
    chk("nack_count", {28'd0, fifo_count}, 0);
    chk("nack_idle",  {31'd0, busy}, 0);
    quiet("nack", 4);
    chk("nack_err_once", err_cnt, e0 + 1);

    // push landing in the commit cycle
    push(8'h55);
    push(8'h66);
    cmd(7'h10, 8'h00, 4'd2);
    xbyte("f5_addr", 8'h20, 1, 0, 0, 0, 1);
    xbyte("f5_reg",  8'h00, 0, 0, 0, 0, 1);
    xbyte("f5_d0",   8'h55, 0, 0, 0, 0, 1);
    xbyte("f5_d1",   8'h66, 0, 1, 0, 0, 1);
    chk("f5_done", {31'd0, done}, 1);
    push(8'h99);
    chk("commit_push_count", {28'd0, fifo_count}, 1);
    cmd(7'h11, 8'h22, 4'd1);
    xbyte("f6_addr", 8'h22, 1, 0, 0, 0, 1);
    xbyte("f6_reg",  8'h22, 0, 0, 0, 0, 1);
    xbyte("f6_d0",   8'h99, 0, 1, 0, 0, 1);
    frame_end("f6", 4'd0);

    // reset while waiting for the data ACK
    push(8'hAB);
    cmd(7'h30, 8'h40, 4'd1);
    xbyte("f7_addr", 8'h60, 1, 0, 0, 0, 1);
    xbyte("f7_reg",  8'h40, 0, 0, 0, 0, 1);
    xbyte("f7_d0",   8'hAB, 0, 1, 0, 0, 0);
    chk("f7_busy", {31'd0, busy}, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle",  {31'd0, busy}, 0);
    chk("mid_rst_tx",    {31'd0, tx_valid}, 0);
    chk("mid_rst_count", {28'd0, fifo_count}, 0);
    rst = 1'b0;
    ack_valid = 1'b1;
    @(negedge clk);
    ack_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done",  done_cnt, d0);
    chk("mid_rst_no_error", err_cnt, e0);
    chk("mid_rst_ready",    {31'd0, cmd_ready}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_write_sequencer.md
I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: data FIFO depth in bytes; power of two, from 2 to 8.
REQ-002 Parameter RETRY_MAX, default 3: maximum number of NACK retries when I2C_SEQ_RETRY_EN is defined.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port cmd_valid, input, 1 bit: write command offered.
REQ-006 Port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both 1.
REQ-007 Port cmd_dev_addr, input, 7 bits: target 7-bit I2C address.
REQ-008 Port cmd_reg_addr, input, 8 bits: target register address.
REQ-009 Port cmd_len, input, 4 bits: number of payload bytes, 0 to FIFO_DEPTH.
REQ-010 Port wr_data_valid, input, 1 bit, with port wr_data, input, 8 bits: payload FIFO push.
REQ-011 Port wr_data_ready, output, 1 bit: high when the FIFO is not full.
REQ-012 Port tx_valid, output, 1 bit, with port tx_byte, output, 8 bits: byte offered to the downstream bit-level transmitter.
REQ-013 Port tx_start, output, 1 bit: downstream SHALL issue START before tx_byte; port tx_stop, output, 1 bit: downstream SHALL issue STOP after the ACK of tx_byte.
REQ-014 Port tx_ready, input, 1 bit: downstream accepts the byte on tx_valid and tx_ready both 1.
REQ-015 Port ack_valid, input, 1 bit, with port ack_nack, input, 1 bit: 1-cycle ACK result for the last accepted byte; ack_nack = 1 means NACK.
REQ-016 Output ports: busy, 1 bit; done, 1 bit, 1-cycle pulse; error, 1 bit, 1-cycle pulse; fifo_count, 4 bits, current FIFO occupancy.

Function
REQ-017 States SHALL be IDLE, WAIT_DATA, SEND_ADDR, WAIT_ACK_ADDR, SEND_REG, WAIT_ACK_REG, SEND_DATA, WAIT_ACK_DATA and FINISH.
REQ-018 cmd_ready SHALL be 1 only in IDLE; on acceptance, dev_addr, reg_addr and len SHALL be latched and the state SHALL go to WAIT_DATA.
REQ-019 If the accepted cmd_len > FIFO_DEPTH, error SHALL pulse on the next cycle, the state SHALL stay IDLE, and no tx_valid SHALL be raised.
REQ-020 WAIT_DATA SHALL go to SEND_ADDR in the cycle in which fifo_count >= len.
REQ-021 SEND_ADDR SHALL drive tx_byte = {dev_addr, 1'b0} and tx_start = 1.
REQ-022 SEND_REG SHALL drive tx_byte = reg_addr; SEND_DATA SHALL drive the FIFO byte at the read pointer.
REQ-023 tx_stop SHALL be 1 on the final byte of the frame: the reg byte when len = 0, otherwise data byte number len.
REQ-024 tx_valid SHALL stay high and tx_byte stable until tx_ready; each SEND_x state SHALL move to its WAIT_ACK_x state on the handshake cycle.
REQ-025 In WAIT_ACK_x, ack_valid with ack_nack = 0 SHALL advance the state: to the next SEND state, or to FINISH after the last byte.
REQ-026 ack_valid outside the WAIT_ACK states SHALL be ignored.
REQ-027 Data bytes SHALL be read through a speculative read pointer; the FIFO head SHALL be committed, popping len bytes, only in FINISH.
REQ-028 FINISH SHALL pulse done for 1 cycle and return to IDLE; the latency from the last ACK to done SHALL be 1 cycle.
REQ-029 On NACK, the speculative read pointer SHALL be restored to the head; behaviour thereafter follows REQ-036 and REQ-037.
REQ-030 A push while the FIFO is full SHALL be dropped and fifo_count SHALL be unchanged.
REQ-031 A push in the same cycle as the FINISH commit SHALL both land; fifo_count SHALL equal old count + 1 - len.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 While rst = 1 at a clock edge, the state SHALL become IDLE, the FIFO SHALL be flushed (fifo_count = 0), and the retry counter SHALL be cleared.
REQ-035 During and after reset: tx_valid, tx_start, tx_stop, done, error and busy SHALL be 0; tx_byte SHALL be 0x00; cmd_ready SHALL be 1 and wr_data_ready SHALL be 1 from the first cycle after rst deasserts; reset mid-frame SHALL abandon the frame with no done or error pulse.

Configuration
REQ-036 With macro I2C_SEQ_RETRY_EN defined, a NACK SHALL increment the retry counter and restart at SEND_ADDR with tx_start = 1 while retries <= RETRY_MAX; otherwise error SHALL pulse, len bytes SHALL be popped, and the state SHALL return to IDLE.
REQ-037 With I2C_SEQ_RETRY_EN undefined, the first NACK SHALL pulse error, pop len bytes and return to IDLE; no retry counter logic SHALL exist.

Verification
REQ-038 Push 0xA5 and 0x3C, then issue command dev 0x48, reg 0x10, len 2 with all ACKs -> tx bytes 0x90(start), 0x10, 0xA5, 0x3C(stop); done pulses once; fifo_count = 0.
REQ-039 Command len 0, dev 0x27, reg 0x05 -> tx bytes 0x4E(start), 0x05(stop); done pulses once.
REQ-040 Command len 3 with only 1 byte pushed -> state stays in WAIT_DATA with no tx_valid until 2 more bytes are pushed, then the full frame is sent.
REQ-041 Hold tx_ready = 0 for 5 cycles -> tx_valid and tx_byte remain stable for all 5 cycles.
REQ-042 With RETRY_EN defined, NACK on the address byte 4 times -> 4 address attempts, then error pulses and the FIFO is emptied; with RETRY_EN undefined -> 1 attempt, then error.
REQ-043 Assert rst during WAIT_ACK_DATA -> IDLE next cycle; fifo_count = 0; tx_valid = 0; no done pulse.
